led_fade_pwm: RTL
=================

Name: led_fade_pwm

Overview:
- Output stage between the LED pattern generator (8-bit on/off pattern) and the board LED pins.
- Converts each hard on/off bit into a PWM-dimmed LED that ramps up and decays at configurable rates, giving an afterglow/trail effect.
- All logic is in the single `clk` domain. The pattern input is registered once on entry.

Parameters:
- NUM_LED, 8, number of LED channels
- PWM_BITS, 8, brightness resolution; LMAX = 2^PWM_BITS-1
- FADE_DIV, 50000, clk cycles per fade step (>=2)
- RISE_STEP, 32, level increment per fade step while target is on (1..LMAX)
- FALL_STEP, 4, level decrement per fade step while target is off (1..LMAX)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- i_led  in  NUM_LED  target pattern from the pattern generator (1 = on)
- i_enable  in  1  run enable; low blanks all LEDs
- o_led  out  NUM_LED  PWM-driven LED pins (1 = lit)
- o_frame_start  out  1  one-cycle pulse marking the first cycle of each PWM frame

Behaviour:
- Reset is applied on `reset_n` low, at any time including mid-ramp. Values during reset:
  - `led_q`, `level[i]`, prescaler and `pwm_cnt` = 0
  - `o_led` = 0
  - `o_frame_start` = 0
- Input register: `led_q <= i_led` every cycle, unconditionally.
- Prescaler:
  - Counts 0..FADE_DIV-1 and wraps.
  - `tick` = (prescaler == FADE_DIV-1).
  - First tick occurs in cycle FADE_DIV-1 after reset release.
- Fade update, performed on each tick for each channel i:
  - `led_q[i]`=1 and `level` < LMAX: `level` <= min(`level`+RISE_STEP, LMAX). Compute with one extra bit, then saturate.
  - `led_q[i]`=0 and `level` > 0: `level` <= max(`level`-FALL_STEP, 0). No underflow wrap.
  - Otherwise `level` holds.
- No tick means all levels hold.
- A bit toggling between ticks has effect only through its value at the tick edge.
- PWM counter:
  - `pwm_cnt` counts 0..LMAX-1 and wraps, so the frame is LMAX cycles long.
  - `level`=LMAX is therefore constantly on; `level`=0 is constantly off.
- Outputs:
  - `o_led[i]` <= (`duty[i]` > `pwm_cnt`), registered.
  - `duty` = `level` when GAMMA_EN is not defined.
  - `o_frame_start` <= (`pwm_cnt` == 0), registered, so it is aligned with the `o_led` value computed from `pwm_cnt`=0.
- Latency:
  - Level change to `o_led`: 1 cycle.
  - `i_led` to first possible level change: 1 cycle plus wait to the next tick.
- Simultaneous tick and `pwm_cnt` wrap: no special case. The new level is used from the next compare.
- `i_enable` low:
  - Prescaler, `pwm_cnt` and all levels are forced to 0 on the next edge.
  - `o_led` = 0 and `o_frame_start` = 0 on the next edge.
- `i_enable` rising: the block restarts exactly as after reset release.

Optional Feature:
- Macro: LED_FADE_GAMMA_EN.
- Defined:
  - `duty[i]` = (`level`*(`level`+1)) >> PWM_BITS, a perceptual square law; 0 maps to 0 and LMAX maps to LMAX.
  - Computed in an extra pipeline register, so level-to-`o_led` latency is 2 cycles.
  - `o_frame_start` is delayed by one more cycle to stay aligned.
- Undefined: `duty` = `level`, latency 1 cycle, no multiplier inferred.

Decomposition:
- Package `led_pkg` holds:
  - Default constants: LED_NUM=8, LED_PWM_BITS=8.
  - Typedef `led_vec_t`.
  - Function `sat_add_sub`: level, step, direction, returns saturated level. Shared by all channels.
- Sub-module `led_fade_channel`, generated NUM_LED times. Per channel it contains:
  - Level register
  - Saturating update
  - Optional gamma stage
  - Compare against the shared `pwm_cnt`
- The top level owns the input register, prescaler, `pwm_cnt` and `o_frame_start`.

Test Plan (sim params PWM_BITS=4 (LMAX=15), FADE_DIV=4, RISE_STEP=4, FALL_STEP=1, gamma off unless stated):
- Reset release with `i_enable`=1, `i_led`=0 -> `o_led`=0 forever; `o_frame_start` pulses every 15 cycles.
- `i_led`=8'h01 held -> ch0 level 4,8,12,15 on successive ticks (4 cycles apart), then constant; `o_led[0]`=1 every cycle once level=15; `o_led[7:1]`=0.
- From level 15, `i_led`=0 -> level decrements 1 per tick, reaching 0 after 15 ticks (60 cycles); at level 6, `o_led[0]` high exactly cycles 0..5 of each 15-cycle frame.
- Mid-ramp (level 8), `i_enable` low for 3 cycles -> `o_led`=0 from the next edge and level reads 0; after re-enable, ramp restarts from 4 at the first tick 4 cycles later.
- Mid-ramp, `reset_n` pulsed low asynchronously between edges -> `o_led`=0 and all levels 0 immediately; behaviour after release is identical to the first scenario.
- LED_FADE_GAMMA_EN defined -> level 4 gives `duty` 1 (high 1 of 15 cycles), level 15 gives `duty` 15 (always on); `o_led` lags the level change by 2 cycles.

Source files
------------

// File: rtl/led_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : led_pkg
//  Purpose  : Shared constants, types and the saturating fade helper used by
//             every LED fade channel.
//  Revision : 1.0 - initial release
// ============================================================================
package led_pkg;

  localparam int LED_NUM      = 8;
  localparam int LED_PWM_BITS = 8;
  // Working width for level arithmetic: wide enough for any PWM_BITS up to 15
  // plus a spare bit so a rising sum can never wrap before saturation.
  localparam int LED_CALC_W   = 17;

  typedef logic [LED_NUM-1:0] led_vec_t;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } fade_dir_e;

  // Move a level one step up (clamped at lmax) or down (clamped at zero).
  function automatic logic [LED_CALC_W-1:0] sat_add_sub(
    input logic [LED_CALC_W-1:0] level,
    input logic [LED_CALC_W-1:0] step,
    input logic [LED_CALC_W-1:0] lmax,
    input fade_dir_e             dir
  );
    logic [LED_CALC_W-1:0] res;
    if (dir == DIR_UP) begin
      res = level + step;
      if (res > lmax) res = lmax;
    end else begin
      if (level > step) res = level - step;
      else              res = '0;
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/led_fade_channel.sv
`default_nettype none
// ============================================================================
//  Module   : led_fade_channel
//  Purpose  : One LED channel: brightness level register with saturating
//             rise/fall on each fade tick, optional square-law gamma stage
//             (LED_FADE_GAMMA_EN), and PWM compare against the shared counter.
//  Revision : 1.0 - initial release
// ============================================================================
module led_fade_channel
  import led_pkg::*;
#(
  parameter int PWM_BITS  = LED_PWM_BITS,
  parameter int RISE_STEP = 32,
  parameter int FALL_STEP = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                i_enable,
  input  logic                i_tick,
  input  logic                i_target,
  input  logic [PWM_BITS-1:0] i_cmp_cnt,
  output logic                o_led
);

  localparam logic [PWM_BITS-1:0]   LMAX   = '1;
  localparam logic [LED_CALC_W-1:0] C_LMAX = LED_CALC_W'(LMAX);
  localparam logic [LED_CALC_W-1:0] C_RISE = LED_CALC_W'(RISE_STEP);
  localparam logic [LED_CALC_W-1:0] C_FALL = LED_CALC_W'(FALL_STEP);

  logic [PWM_BITS-1:0] level_q, level_d;
  logic [PWM_BITS-1:0] duty;
  logic                led_q, led_d;

  // Level update: only moves on a tick, towards the target, saturating.
  always_comb begin
    level_d = level_q;
    if (!i_enable) begin
      level_d = '0;
    end else if (i_tick) begin
      if (i_target && (level_q != LMAX)) begin
        level_d = PWM_BITS'(sat_add_sub(LED_CALC_W'(level_q), C_RISE, C_LMAX, DIR_UP));
      end else if (!i_target && (level_q != '0)) begin
        level_d = PWM_BITS'(sat_add_sub(LED_CALC_W'(level_q), C_FALL, C_LMAX, DIR_DOWN));
      end
    end
  end

`ifdef LED_FADE_GAMMA_EN
  logic [2*PWM_BITS-1:0] sq;
  logic [PWM_BITS-1:0]   duty_q, duty_d;

  // Square-law duty: level*(level+1) keeps 0->0 and LMAX->LMAX exactly.
  always_comb begin
    sq     = (2*PWM_BITS)'(level_q) * ((2*PWM_BITS)'(level_q) + (2*PWM_BITS)'(1));
    duty_d = i_enable ? PWM_BITS'(sq >> PWM_BITS) : '0;
  end

  // Gamma pipeline register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) duty_q <= '0;
    else          duty_q <= duty_d;
  end

  assign duty = duty_q;
`else
  assign duty = level_q;
`endif

  // PWM compare; disabled channel goes dark on the next edge.
  always_comb begin
    led_d = i_enable && (duty > i_cmp_cnt);
  end

  // Level and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level_q <= '0;
      led_q   <= 1'b0;
    end else begin
      level_q <= level_d;
      led_q   <= led_d;
    end
  end

  assign o_led = led_q;

endmodule
`default_nettype wire

// File: rtl/led_fade_pwm.sv
`default_nettype none
// ============================================================================
//  Module   : led_fade_pwm
//  Purpose  : PWM fade output stage for the LED pattern generator. Registers
//             the pattern, runs the fade prescaler and shared PWM counter,
//             and instantiates one fade channel per LED.
//             Optional macro LED_FADE_GAMMA_EN adds a square-law gamma stage
//             (one extra cycle of latency on o_led and o_frame_start).
//  Revision : 1.0 - initial release
// ============================================================================
module led_fade_pwm
  import led_pkg::*;
#(
  parameter int NUM_LED   = LED_NUM,
  parameter int PWM_BITS  = LED_PWM_BITS,
  parameter int FADE_DIV  = 50000,
  parameter int RISE_STEP = 32,
  parameter int FALL_STEP = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_LED-1:0] i_led,
  input  logic               i_enable,
  output logic [NUM_LED-1:0] o_led,
  output logic               o_frame_start
);

  localparam int                  DIV_W    = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(FADE_DIV - 1);
  // Frame is LMAX cycles long, so the counter wraps after LMAX-1.
  localparam logic [PWM_BITS-1:0] CNT_LAST = {{(PWM_BITS-1){1'b1}}, 1'b0};

  logic [NUM_LED-1:0]  led_q, led_d;
  logic [DIV_W-1:0]    presc_q, presc_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic                frame_start_q, frame_start_d;
  logic                tick;
  logic [PWM_BITS-1:0] cmp_cnt;
  logic [NUM_LED-1:0]  ch_led;

  assign tick = (presc_q == DIV_LAST);

  // Input register, prescaler and PWM counter next-state.
  always_comb begin
    led_d     = i_led;
    presc_d   = '0;
    pwm_cnt_d = '0;
    if (i_enable) begin
      presc_d   = tick ? '0 : presc_q + DIV_W'(1);
      pwm_cnt_d = (pwm_cnt_q == CNT_LAST) ? '0 : pwm_cnt_q + PWM_BITS'(1);
    end
  end

`ifdef LED_FADE_GAMMA_EN
  logic [PWM_BITS-1:0] cmp_cnt_q, cmp_cnt_d;

  // Delay the compare counter to line up with the gamma duty register.
  always_comb begin
    cmp_cnt_d = i_enable ? pwm_cnt_q : '0;
  end

  // Delayed compare counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cmp_cnt_q <= '0;
    else          cmp_cnt_q <= cmp_cnt_d;
  end

  assign cmp_cnt = cmp_cnt_q;
`else
  assign cmp_cnt = pwm_cnt_q;
`endif

  // Frame marker tracks the counter value the channels compare against.
  always_comb begin
    frame_start_d = i_enable && (cmp_cnt == '0);
  end

  // Shared control registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      led_q         <= '0;
      presc_q       <= '0;
      pwm_cnt_q     <= '0;
      frame_start_q <= 1'b0;
    end else begin
      led_q         <= led_d;
      presc_q       <= presc_d;
      pwm_cnt_q     <= pwm_cnt_d;
      frame_start_q <= frame_start_d;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_LED; gi++) begin : g_ch
      led_fade_channel #(
        .PWM_BITS (PWM_BITS),
        .RISE_STEP(RISE_STEP),
        .FALL_STEP(FALL_STEP)
      ) u_ch (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_enable (i_enable),
        .i_tick   (tick),
        .i_target (led_q[gi]),
        .i_cmp_cnt(cmp_cnt),
        .o_led    (ch_led[gi])
      );
    end
  endgenerate

  assign o_led         = ch_led;
  assign o_frame_start = frame_start_q;

endmodule
`default_nettype wire
